rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
- Parametrised, registered successor to the team's 8-bit casez priority encoder.
- Selects one of N request lines and encodes the winner as a binary index and a one-hot vector.
- Two arbitration modes: fixed priority (lowest index wins) or rotating round-robin priority.
- The grant is held with a valid/ack handshake, so it can arbitrate shared resources directly.

Parameters:
- N, 8, number of request lines; must be >= 2; need not be a power of two.
- W, $clog2(N), width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- req  input  N  request vector; bit i = requester i.
- gnt_ack  input  1  consumer accepts the current grant; meaningful only while gnt_valid = 1.
- gnt_valid  output  1  a grant is presented and held stable.
- gnt_pos  output  W  binary index of the granted requester.
- gnt_onehot  output  N  one-hot form of gnt_pos; all zeros when gnt_valid = 0.
- any_req  output  1  combinational OR of req; independent of state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, sampled on the rising edge; it has priority over every other event.
- Reset values:
  - state = IDLE
  - gnt_valid = 0
  - gnt_pos = 0
  - gnt_onehot = 0
  - rotation pointer ptr = 0
- States: IDLE and HOLD.
- IDLE:
  - If req != 0, compute the winner and register it: gnt_pos, gnt_onehot = 1 << gnt_pos, gnt_valid = 1, next state HOLD.
  - If req == 0, stay in IDLE with outputs unchanged: gnt_valid = 0, gnt_onehot = 0, gnt_pos holds its last value.
  - Latency: req sampled at edge k gives gnt_valid = 1 after edge k.
- Winner selection:
  - mode = 0: lowest set index of req, starting from index 0; ptr is ignored.
  - mode = 1: lowest set index i with i >= ptr. If there is none, the lowest set index overall (wrap-around).
  - mode is sampled only at the IDLE arbitration edge. A change while in HOLD has no effect on the current grant.
- HOLD:
  - gnt_pos, gnt_onehot and gnt_valid hold stable until gnt_ack = 1 is sampled.
  - A requester dropping its req does not revoke the grant.
  - Changes on other req bits are ignored.
- On gnt_ack in HOLD, at the same edge:
  - gnt_valid goes to 0 and gnt_onehot to 0; next state IDLE.
  - If mode = 1 was in effect for this grant, ptr = (gnt_pos + 1) mod N. For gnt_pos = N-1, ptr wraps to 0, including when N is not a power of two.
  - If mode = 0, ptr is unchanged.
- gnt_ack in IDLE is ignored.
- Throughput: at most one grant per 2 cycles (the ack edge, then the arbitration edge). No back-to-back grants.
- Reset asserted mid-HOLD: the grant is dropped on that edge with no ack required, and ptr returns to 0.
- Reset and gnt_ack asserted together: reset wins and ptr = 0.
- any_req is purely combinational and is unaffected by reset.
- With mode = 0 held, gnt_pos must equal the encoding of the 8-bit casez priority encoder for N = 8.

Test Plan:
- Reset then fixed priority: assert reset for 2 cycles, then N = 8, mode = 0, req = 8'b0110_1000 → one edge later gnt_valid = 1, gnt_pos = 3, gnt_onehot = 8'b0000_1000. Pulse gnt_ack → gnt_valid = 0, and the next grant is again 3.
- Round-robin rotation: mode = 1, req = 8'hFF held, ack each grant → gnt_pos sequence 0,1,2,…,7,0, with ptr wrapping 7 → 0. Grant spacing is exactly 2 cycles.
- Round-robin skip and wrap: mode = 1, ptr = 6 (after granting 5), req = 8'b0000_0101 → gnt_pos = 0. After ack, ptr = 1, and the next grant is 2.
- Hold stability: grant 4 issued, then req drops to 0 and mode toggles for 5 cycles without ack → gnt_valid, gnt_pos = 4 and gnt_onehot stay stable. The ack then clears them, and any_req = 0.
- Reset mid-operation: in HOLD with gnt_pos = 5 and ptr = 3, assert reset together with gnt_ack → next cycle gnt_valid = 0, gnt_pos = 0, ptr = 0. Then req = 8'h80 with mode = 1 → gnt_pos = 7.
- Non-power-of-two: N = 5 (W = 3), mode = 1, req = 5'b1_0001, ack every grant → gnt_pos alternates 0,4,0,4. ptr never exceeds 4, and after the grant at 4 it wraps to 0.

Source files
------------

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle shared by the round-robin priority arbiter and its
// consumers. The master side owns requests, mode and acknowledge; the slave
// side (the arbiter) owns the grant outputs and the any_req summary.
interface rr_priority_arbiter_if #(
    parameter int N = 8
) ();
    localparam int W = $clog2(N);

    logic         mode;
    logic [N-1:0] req;
    logic         gnt_ack;
    logic         gnt_valid;
    logic [W-1:0] gnt_pos;
    logic [N-1:0] gnt_onehot;
    logic         any_req;

    modport master (
        output mode,
        output req,
        output gnt_ack,
        input  gnt_valid,
        input  gnt_pos,
        input  gnt_onehot,
        input  any_req
    );

    modport slave (
        input  mode,
        input  req,
        input  gnt_ack,
        output gnt_valid,
        output gnt_pos,
        output gnt_onehot,
        output any_req
    );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with fixed (index 0 highest) or rotating
// round-robin priority. A grant is presented with gnt_valid and held
// unchanged until the consumer acknowledges it, so the block can guard a
// shared resource directly. With mode = 0 the winner matches the old 8-bit
// casez priority encoder (lowest set index wins).
module rr_priority_arbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input logic               clk,
    input logic               reset,
    rr_priority_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         gnt_valid;
    logic         gnt_valid_next;
    logic [W-1:0] gnt_pos;
    logic [W-1:0] gnt_pos_next;
    logic [N-1:0] gnt_onehot;
    logic [N-1:0] gnt_onehot_next;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic         rr_grant;
    logic         rr_grant_next;

    logic [N-1:0] rr_mask;
    logic [N-1:0] masked_req;
    logic [W-1:0] winner;

    // Lowest set bit of a request vector, encoded as a binary index.
    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    // Winner selection: round-robin searches from ptr upward and wraps to the
    // lowest requester when nothing at or above ptr is asking.
    always_comb begin
        rr_mask    = '0;
        masked_req = '0;
        winner     = '0;
        for (int i = 0; i < N; i++) begin
            rr_mask[i] = (W'(i) >= ptr);
        end
        masked_req = bus.req & rr_mask;
        if (bus.mode && (masked_req != '0)) begin
            winner = lowest_set(masked_req);
        end else begin
            winner = lowest_set(bus.req);
        end
    end

    // State and grant registers; reset drops any grant and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_pos    <= '0;
            gnt_onehot <= '0;
            ptr        <= '0;
            rr_grant   <= 1'b0;
        end else begin
            state      <= state_next;
            gnt_valid  <= gnt_valid_next;
            gnt_pos    <= gnt_pos_next;
            gnt_onehot <= gnt_onehot_next;
            ptr        <= ptr_next;
            rr_grant   <= rr_grant_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until it is acked,
    // and advance the pointer only for grants made in round-robin mode.
    always_comb begin
        state_next      = state;
        gnt_valid_next  = gnt_valid;
        gnt_pos_next    = gnt_pos;
        gnt_onehot_next = gnt_onehot;
        ptr_next        = ptr;
        rr_grant_next   = rr_grant;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    gnt_pos_next    = winner;
                    gnt_onehot_next = N'(1) << winner;
                    gnt_valid_next  = 1'b1;
                    rr_grant_next   = bus.mode;
                    state_next      = HOLD;
                end
            end
            HOLD: begin
                if (bus.gnt_ack) begin
                    gnt_valid_next  = 1'b0;
                    gnt_onehot_next = '0;
                    state_next      = IDLE;
                    if (rr_grant) begin
                        ptr_next = (gnt_pos == W'(N - 1)) ? '0 : gnt_pos + W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.gnt_valid  = gnt_valid;
    assign bus.gnt_pos    = gnt_pos;
    assign bus.gnt_onehot = gnt_onehot;
    assign bus.any_req    = |bus.req;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for the round-robin priority arbiter: an N = 8 instance for
// fixed and rotating priority, hold and reset behaviour, plus an N = 5
// instance for pointer wrap on a non-power-of-two width.
module tb_rr_priority_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   assert_count = 0;
    int   fail_count   = 0;

    rr_priority_arbiter_if #(.N(8)) bus8 ();
    rr_priority_arbiter_if #(.N(5)) bus5 ();

    rr_priority_arbiter #(.N(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    rr_priority_arbiter #(.N(5)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic m, input logic [7:0] r, input logic a);
        bus8.mode    = m;
        bus8.req     = r;
        bus8.gnt_ack = a;
    endtask

    task automatic apply_stimulus_n5(input logic m, input logic [4:0] r, input logic a);
        bus5.mode    = m;
        bus5.req     = r;
        bus5.gnt_ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant8(input string tag, input logic v, input int p, input logic [7:0] oh);
        check_output({tag, "_valid"}, 32'(bus8.gnt_valid), 32'(v));
        check_output({tag, "_pos"}, 32'(bus8.gnt_pos), 32'(p));
        check_output({tag, "_onehot"}, 32'(bus8.gnt_onehot), 32'(oh));
    endtask

    task automatic check_grant5(input string tag, input logic v, input int p, input logic [4:0] oh);
        check_output({tag, "_valid"}, 32'(bus5.gnt_valid), 32'(v));
        check_output({tag, "_pos"}, 32'(bus5.gnt_pos), 32'(p));
        check_output({tag, "_onehot"}, 32'(bus5.gnt_onehot), 32'(oh));
    endtask

    initial begin
        logic [7:0] enc_req [4];
        int         enc_pos [4];
        enc_req[0] = 8'h80;        enc_pos[0] = 7;
        enc_req[1] = 8'hFE;        enc_pos[1] = 1;
        enc_req[2] = 8'h01;        enc_pos[2] = 0;
        enc_req[3] = 8'b0101_0000; enc_pos[3] = 4;

        $display("[TB] start");
        reset = 1'b1;
        apply_stimulus(1'b0, 8'h10, 1'b0);
        apply_stimulus_n5(1'b0, 5'b0, 1'b0);

        // Reset for two cycles; any_req follows req even while reset is high.
        tick();
        tick();
        check_output("reset_any_req_hi", 32'(bus8.any_req), 32'd1);
        check_grant8("reset", 1'b0, 0, 8'h00);
        check_output("reset_ptr", 32'(dut8.ptr), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        #1;
        check_output("reset_any_req_lo", 32'(bus8.any_req), 32'd0);
        reset = 1'b0;

        // Ack while idle is ignored.
        apply_stimulus(1'b0, 8'h00, 1'b1);
        tick();
        check_grant8("idle_ack", 1'b0, 0, 8'h00);

        // Fixed priority: lowest set bit wins, and wins again after the ack.
        apply_stimulus(1'b0, 8'b0110_1000, 1'b0);
        tick();
        check_grant8("fixed_1", 1'b1, 3, 8'b0000_1000);
        apply_stimulus(1'b0, 8'b0110_1000, 1'b1);
        tick();
        check_grant8("fixed_ack", 1'b0, 3, 8'h00);
        apply_stimulus(1'b0, 8'b0110_1000, 1'b0);
        tick();
        check_grant8("fixed_2", 1'b1, 3, 8'b0000_1000);
        apply_stimulus(1'b0, 8'b0110_1000, 1'b1);
        tick();
        check_output("fixed_ptr", 32'(dut8.ptr), 32'd0);

        // Round-robin sweep with every requester active: 0..7 then back to 0.
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(1'b1, 8'hFF, 1'b0);
            tick();
            check_grant8($sformatf("rr_seq%0d", k), 1'b1, k % 8, 8'(1 << (k % 8)));
            apply_stimulus(1'b1, 8'hFF, 1'b1);
            tick();
            check_output($sformatf("rr_seq%0d_off", k), 32'(bus8.gnt_valid), 32'd0);
            check_output($sformatf("rr_seq%0d_ptr", k), 32'(dut8.ptr), 32'((k + 1) % 8));
        end

        // Skip and wrap: grant 5 moves ptr to 6, then only 0 and 2 request.
        apply_stimulus(1'b1, 8'b0010_0000, 1'b0);
        tick();
        check_grant8("rr_five", 1'b1, 5, 8'b0010_0000);
        apply_stimulus(1'b1, 8'b0010_0000, 1'b1);
        tick();
        check_output("rr_ptr6", 32'(dut8.ptr), 32'd6);
        apply_stimulus(1'b1, 8'b0000_0101, 1'b0);
        tick();
        check_grant8("rr_wrap", 1'b1, 0, 8'b0000_0001);
        apply_stimulus(1'b1, 8'b0000_0101, 1'b1);
        tick();
        check_output("rr_ptr1", 32'(dut8.ptr), 32'd1);
        apply_stimulus(1'b1, 8'b0000_0101, 1'b0);
        tick();
        check_grant8("rr_two", 1'b1, 2, 8'b0000_0100);
        apply_stimulus(1'b1, 8'b0000_0101, 1'b1);
        tick();
        check_output("rr_ptr3", 32'(dut8.ptr), 32'd3);

        // Hold stability: fixed-mode grant of 4 survives req dropping and mode toggling.
        apply_stimulus(1'b0, 8'b0001_0000, 1'b0);
        tick();
        check_grant8("hold_start", 1'b1, 4, 8'b0001_0000);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'(k % 2 == 0), 8'h00, 1'b0);
            tick();
            check_grant8($sformatf("hold%0d", k), 1'b1, 4, 8'b0001_0000);
        end
        apply_stimulus(1'b1, 8'h00, 1'b1);
        tick();
        check_grant8("hold_ack", 1'b0, 4, 8'h00);
        check_output("hold_any_req", 32'(bus8.any_req), 32'd0);
        check_output("hold_ptr", 32'(dut8.ptr), 32'd3);

        // Reset together with ack mid-grant: reset wins and ptr rewinds.
        apply_stimulus(1'b1, 8'b0010_0000, 1'b0);
        tick();
        check_grant8("pre_reset", 1'b1, 5, 8'b0010_0000);
        reset = 1'b1;
        apply_stimulus(1'b1, 8'b0010_0000, 1'b1);
        tick();
        check_grant8("mid_reset", 1'b0, 0, 8'h00);
        check_output("mid_reset_ptr", 32'(dut8.ptr), 32'd0);
        reset = 1'b0;
        apply_stimulus(1'b1, 8'h80, 1'b0);
        tick();
        check_grant8("post_reset", 1'b1, 7, 8'h80);
        apply_stimulus(1'b1, 8'h80, 1'b1);
        tick();
        check_output("post_reset_ptr", 32'(dut8.ptr), 32'd0);

        // Fixed mode matches the legacy casez encoder.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, enc_req[k], 1'b0);
            tick();
            check_grant8($sformatf("enc%0d", k), 1'b1, enc_pos[k], 8'(1 << enc_pos[k]));
            apply_stimulus(1'b0, enc_req[k], 1'b1);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0);

        // N = 5: requesters 0 and 4 alternate and ptr wraps from 4 back to 0.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus_n5(1'b1, 5'b1_0001, 1'b0);
            tick();
            check_grant5($sformatf("n5_%0d", k), 1'b1, (k % 2 == 0) ? 0 : 4,
                         (k % 2 == 0) ? 5'b0_0001 : 5'b1_0000);
            apply_stimulus_n5(1'b1, 5'b1_0001, 1'b1);
            tick();
            check_output($sformatf("n5_%0d_ptr", k), 32'(dut5.ptr),
                         (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
